// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clk_div_ctrl: glitch-free run/stop controller for an integer     |
// | clock divider with period-aligned ratio updates.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module clk_div_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DIV_DEF = 3
) (
   input  logic             iclk,
   input  logic             rstn,
   input  logic             en,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             oclk,
   output logic             oclk_ce,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STOP = 2'd2;

   localparam logic [CNT_W-1:0] C_DIV_DEF = CNT_W'(DIV_DEF);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             oclk_q, oclk_d;
   logic             ce_q, ce_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_v_q, pend_v_d;

   logic             w_active;
   logic             w_bnd;
   logic             w_accept;
   logic             w_legal;
   logic [CNT_W:0]   w_half;

   always_comb begin
      w_active = (state_q != S_IDLE);
      w_bnd    = w_active && (cnt_q == (cur_div_q - CNT_W'(1)));
      w_accept = cfg_valid && !pend_v_q;
      w_legal  = (cfg_div >= CNT_W'(2));

      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (en) state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = w_bnd ? '0 : cnt_q + CNT_W'(1);
            if (!en) state_d = w_bnd ? S_IDLE : S_STOP;
         end
         S_STOP: begin
            cnt_d = w_bnd ? '0 : cnt_q + CNT_W'(1);
            if (en)         state_d = S_RUN;
            else if (w_bnd) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (state_d == S_IDLE) cnt_d = '0;

      // Ratio changes only land at a period boundary (or while idle).
      cur_div_d = cur_div_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      err_d     = w_accept && !w_legal;
      if (!w_active) begin
         if (w_accept && w_legal) cur_div_d = cfg_div;
      end else if (w_bnd) begin
         if (w_accept && w_legal) begin
            cur_div_d = cfg_div;
         end else if (pend_v_q) begin
            cur_div_d = pend_q;
            pend_v_d  = 1'b0;
         end
      end else if (w_accept && w_legal) begin
         pend_d   = cfg_div;
         pend_v_d = 1'b1;
      end

      // Outputs are registered in step with cnt, using the ratio of the period cnt_d belongs to.
      w_half = ({1'b0, cur_div_d} + (CNT_W+1)'(1)) >> 1;
      oclk_d = (state_d != S_IDLE) && ({1'b0, cnt_d} < w_half);
      ce_d   = (state_d != S_IDLE) && (cnt_d == '0);
   end

   always_ff @(posedge iclk) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         oclk_q    <= 1'b0;
         ce_q      <= 1'b0;
         err_q     <= 1'b0;
         cur_div_q <= C_DIV_DEF;
         pend_q    <= '0;
         pend_v_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         oclk_q    <= oclk_d;
         ce_q      <= ce_d;
         err_q     <= err_d;
         cur_div_q <= cur_div_d;
         pend_q    <= pend_d;
         pend_v_q  <= pend_v_d;
      end
   end

   assign cfg_ready = ~pend_v_q;
   assign cfg_err   = err_q;
   assign oclk      = oclk_q;
   assign oclk_ce   = ce_q;
   assign busy      = (state_q != S_IDLE);
   assign cur_div   = cur_div_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_clk_div_ctrl;

   localparam int CNT_W = 8;

   logic             iclk;
   logic             rstn;
   logic             en;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_err;
   logic             oclk;
   logic             oclk_ce;
   logic             busy;
   logic [CNT_W-1:0] cur_div;

   int n_checks = 0;
   int n_errors = 0;

   clk_div_ctrl #(.CNT_W(CNT_W), .DIV_DEF(3)) u_dut (
      .iclk      (iclk),
      .rstn      (rstn),
      .en        (en),
      .cfg_div   (cfg_div),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .oclk      (oclk),
      .oclk_ce   (oclk_ce),
      .busy      (busy),
      .cur_div   (cur_div)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   // After each tick, check oclk and oclk_ce against expected values.
   task automatic tick_chk(input string tag, input logic exp_oclk, input logic exp_ce);
      tick();
      chk({tag, ".oclk"}, oclk, exp_oclk);
      chk({tag, ".ce"}, oclk_ce, exp_ce);
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; cfg_div = '0; cfg_valid = 1'b0;

      // Reset
      tick(); tick();
      chk("rst.oclk", oclk, 0);
      chk("rst.ce", oclk_ce, 0);
      chk("rst.busy", busy, 0);
      chk("rst.ready", cfg_ready, 1);
      chk("rst.err", cfg_err, 0);
      chk("rst.cur_div", cur_div, 3);

      // Default N=3 run
      rstn = 1'b1; en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick_chk("run3", (i % 3) != 2, (i % 3) == 0);
         chk("run3.busy", busy, 1);
      end
      en = 1'b0;
      tick_chk("stop3", 0, 0);
      chk("stop3.busy", busy, 0);

      // Mid-run reconfigure to 4, accepted at cnt==0
      en = 1'b1;
      tick_chk("rc.p0c0", 1, 1);
      cfg_div = 8'd4; cfg_valid = 1'b1;
      tick_chk("rc.p0c1", 1, 0);
      cfg_valid = 1'b0;
      chk("rc.ready_lo", cfg_ready, 0);
      chk("rc.div_old", cur_div, 3);
      tick_chk("rc.p0c2", 0, 0);
      chk("rc.ready_lo2", cfg_ready, 0);
      chk("rc.div_old2", cur_div, 3);
      tick_chk("rc.p1c0", 1, 1);
      chk("rc.div_new", cur_div, 4);
      chk("rc.ready_hi", cfg_ready, 1);
      tick_chk("rc.p1c1", 1, 0);
      tick_chk("rc.p1c2", 0, 0);
      tick_chk("rc.p1c3", 0, 0);
      tick_chk("rc.p2c0", 1, 1);

      // Accept 5 exactly at the boundary: next period uses it directly
      tick(); tick(); tick();
      cfg_div = 8'd5; cfg_valid = 1'b1;
      tick_chk("bnd.c0", 1, 1);
      cfg_valid = 1'b0;
      chk("bnd.div", cur_div, 5);
      chk("bnd.ready", cfg_ready, 1);
      tick_chk("bnd.c1", 1, 0);
      tick_chk("bnd.c2", 1, 0);
      tick_chk("bnd.c3", 0, 0);
      tick_chk("bnd.c4", 0, 0);
      tick_chk("bnd.n0", 1, 1);

      // Move to N=6
      cfg_div = 8'd6; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick(); tick(); tick();
      tick_chk("n6.c0", 1, 1);
      chk("n6.div", cur_div, 6);

      // Stop at cnt==1: period completes then idles
      tick();
      en = 1'b0;
      tick_chk("stp.c2", 1, 0);
      chk("stp.busy2", busy, 1);
      tick_chk("stp.c3", 0, 0);
      tick_chk("stp.c4", 0, 0);
      tick_chk("stp.c5", 0, 0);
      chk("stp.busy5", busy, 1);
      tick_chk("stp.idle", 0, 0);
      chk("stp.busy_lo", busy, 0);
      tick_chk("stp.idle2", 0, 0);

      // Stop then resume at cnt==3: no gap
      en = 1'b1;
      tick_chk("res.c0", 1, 1);
      tick();
      en = 1'b0;
      tick();
      tick();
      en = 1'b1;
      tick_chk("res.c4", 0, 0);
      tick_chk("res.c5", 0, 0);
      chk("res.busy", busy, 1);
      tick_chk("res.n0", 1, 1);

      // Illegal configs
      cfg_div = 8'd0; cfg_valid = 1'b1;
      tick_chk("ill0.c1", 1, 0);
      cfg_valid = 1'b0;
      chk("ill0.err", cfg_err, 1);
      chk("ill0.div", cur_div, 6);
      chk("ill0.ready", cfg_ready, 1);
      tick_chk("ill0.c2", 1, 0);
      chk("ill0.err_lo", cfg_err, 0);
      cfg_div = 8'd1; cfg_valid = 1'b1;
      tick_chk("ill1.c3", 0, 0);
      cfg_valid = 1'b0;
      chk("ill1.err", cfg_err, 1);
      chk("ill1.div", cur_div, 6);
      tick_chk("ill1.c4", 0, 0);
      chk("ill1.err_lo", cfg_err, 0);
      tick_chk("ill1.c5", 0, 0);
      tick_chk("ill1.n0", 1, 1);
      chk("ill1.div2", cur_div, 6);

      // Reset mid-period with a pending config
      cfg_div = 8'd5; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick(); tick(); tick(); tick();
      tick_chk("mr.c0", 1, 1);
      chk("mr.div5", cur_div, 5);
      tick();
      cfg_div = 8'd7; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("mr.pend", cfg_ready, 0);
      rstn = 1'b0;
      tick_chk("mr.rst", 0, 0);
      chk("mr.busy", busy, 0);
      chk("mr.ready", cfg_ready, 1);
      chk("mr.div", cur_div, 3);
      rstn = 1'b1;
      tick_chk("mr.r0", 1, 1);
      tick_chk("mr.r1", 1, 0);
      tick_chk("mr.r2", 0, 0);
      tick_chk("mr.r3", 1, 1);
      chk("mr.div_after", cur_div, 3);

      // Accept on the same edge as IDLE->RUN applies to the first period
      tick(); tick();
      en = 1'b0;
      tick();
      chk("st.idle", busy, 0);
      en = 1'b1; cfg_div = 8'd2; cfg_valid = 1'b1;
      tick_chk("st.c0", 1, 1);
      cfg_valid = 1'b0;
      chk("st.div", cur_div, 2);
      tick_chk("st.c1", 0, 0);
      tick_chk("st.n0", 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time controller for an integer clock divider on the `iclk` domain.
- Sequences start and stop of the divided clock `oclk` so that every period is complete (no runt pulses).
- Accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries.
- Emits a one-cycle clock-enable pulse per output period for downstream logic on `iclk`.

Parameters:
- CNT_W, 8, width of divide ratio and period counter.
- DIV_DEF, 3, divide ratio after reset; must satisfy 2 <= DIV_DEF <= 2^CNT_W-1.

Ports:
- iclk  input  1  system clock; all logic rising-edge.
- rstn  input  1  synchronous active-low reset.
- en  input  1  level; 1 = run divided clock, 0 = stop after current period.
- cfg_div  input  CNT_W  requested divide ratio N.
- cfg_valid  input  1  cfg_div valid.
- cfg_ready  output  1  controller can accept a config.
- cfg_err  output  1  one-cycle pulse: accepted config was illegal (N<2) and discarded.
- oclk  output  1  divided clock, registered.
- oclk_ce  output  1  one-cycle pulse on the first `iclk` cycle of each oclk high phase.
- busy  output  1  1 when state != IDLE.
- cur_div  output  CNT_W  ratio currently in effect.

Behaviour:
- Clock and reset: one clock (`iclk`, rising edge); reset `rstn` is synchronous and active-low.
- Reset values (rstn=0 at an edge): state IDLE, cnt 0, oclk 0, oclk_ce 0, busy 0, cfg_ready 1, cfg_err 0, cur_div DIV_DEF, pending config cleared.
- Reset mid-operation: all of the above take effect at the next edge; the in-flight period is truncated and any pending config is discarded.
- States:
  - IDLE: oclk=0, cnt=0.
  - RUN: counting.
  - STOP: counting, finishing the current period.
- Period definition, ratio N=cur_div: cnt runs 0..N-1 and wraps. H=(N+1)>>1. oclk=1 for cnt<H, else 0. So the period is N cycles, high H cycles, low N-H cycles. Even N gives 50% duty; odd N gives one extra high cycle.
- Boundary: the `iclk` cycle in which cnt==N-1 (RUN or STOP).
- Transitions:
  - IDLE->RUN: on the edge sampling en=1. Same edge sets cnt=0, oclk=1, oclk_ce=1. Latency from en sampled to oclk high is 0 edges (registered on that edge).
  - RUN->STOP: en=0 sampled while not at a boundary.
  - RUN->IDLE: en=0 sampled at a boundary. Next cycle oclk=0, busy=0.
  - STOP->IDLE: at a boundary.
  - STOP->RUN: en=1 sampled. Counting continues with no gap and no restart.
- oclk_ce=1 exactly in cycles where cnt==0 and state is RUN or STOP; 0 otherwise.
- Config handshake:
  - Accept = cfg_valid & cfg_ready.
  - cfg_ready = ~pending_valid. cfg_valid held while cfg_ready=0 must not be lost.
  - cfg_div < 2: accept, discard, cfg_err=1 for the one cycle after accept. cur_div and pending are unchanged.
  - Legal cfg_div in IDLE: cur_div updates on the accept edge; nothing is pended.
  - Legal cfg_div in RUN/STOP, not at a boundary: store in pending, pending_valid=1.
  - At a boundary with pending_valid: cur_div <= pending and pending_valid=0, effective for the period beginning next cycle.
  - Accept coinciding with a boundary: the new value applies directly to the next period; nothing is pended.
  - Accept on the same edge as IDLE->RUN: the new value applies to the first period.
- Pending at stop: if the block returns to IDLE with pending_valid=1, the pending value is applied on that same edge.
- Width rules: cnt and compares are CNT_W bits unsigned. H is computed from the N in effect for the current period; it never changes mid-period.

Test Plan:
- Reset: assert rstn=0 for 2 cycles -> oclk=0, oclk_ce=0, busy=0, cfg_ready=1, cur_div=3.
- Default run: en=1 held 9 cycles -> oclk=1,1,0,1,1,0,1,1,0; oclk_ce=1,0,0,1,0,0,1,0,0; busy=1 from the first edge.
- Mid-run reconfigure: running N=3, accept cfg_div=4 at cnt==0 -> current period stays 1,1,0; next period 1,1,0,0; cur_div becomes 4 one cycle after the boundary; cfg_ready=0 until then. Also accept at cnt==2 (boundary) -> the next period uses 4 immediately.
- Stop and resume: N=6, drop en at cnt==1 -> oclk completes 1,1,0,0,0 then stays 0 and busy falls. Repeat with en reasserted at cnt==3 -> no gap, period continues.
- Illegal config: cfg_div=0, then 1, with cfg_valid=1 -> cfg_err pulses one cycle each; cur_div unchanged; oclk pattern unaffected.
- Reset mid-period: N=5, rstn=0 at cnt==2 -> oclk=0 on the next edge. A pending cfg_div=7 is discarded; cur_div returns to 3.
